// File: rtl/pal_pkg.sv
// Shared PAL configuration constants, sizing helpers and the loader state encoding.
// The PAL and its loader both size the configuration chain from these functions.
package pal_pkg;

    localparam int BYTE_W = 8;

    function automatic int pal_sr_len(input int n, input int m, input int p);
        return 2 * n * p + p * m;
    endfunction

    function automatic int pal_cfg_bytes(input int len);
        return (len + BYTE_W - 1) / BYTE_W;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/pal_cfg_piso.sv
// Byte hold buffer feeding an 8-bit MSB-first shifter; emits a registered serial bit/valid pair.
// The shifter reloads on the edge that emits its last bit, so back-to-back bytes shift without gaps.
module pal_cfg_piso
    import pal_pkg::*;
#(
    parameter int LIM_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    input  logic [LIM_W-1:0]  limit_i,
    output logic              shift_o,
    output logic              ser_data_o,
    output logic              ser_valid_o
);

    localparam int CNT_W = $clog2(BYTE_W + 1);

    logic [BYTE_W-1:0] hold_q;
    logic              hold_full_q;
    logic [BYTE_W-1:0] sh_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ser_valid_q;
    logic              ser_data_q;

    logic accept;
    logic drain;
    logic load;

    // A zero limit stops shifting; this is how the unused low bits of the last byte get discarded.
    assign shift_o      = (cnt_q != '0) && (limit_i != '0);
    assign drain        = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && shift_o);
    assign load         = hold_full_q && drain;
    assign byte_ready_o = !hold_full_q;
    assign accept       = byte_valid_i && !hold_full_q;
    assign ser_valid_o  = ser_valid_q;
    assign ser_data_o   = ser_data_q;

    // NOTE: every register here updates with <= so all reads in this edge see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            ser_valid_q <= 1'b0;
            ser_data_q  <= 1'b0;
        end else begin
            ser_valid_q <= shift_o;
            if (shift_o) begin
                ser_data_q <= sh_q[BYTE_W-1];
            end
            if (load) begin
                sh_q  <= hold_q;
                cnt_q <= CNT_W'(BYTE_W);
            end else if (shift_o) begin
                sh_q  <= sh_q << 1;
                cnt_q <= cnt_q - 1'b1;
            end
            if (accept) begin
                hold_q      <= byte_i;
                hold_full_q <= 1'b1;
            end else if (load) begin
                hold_full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pal_cfg_loader.sv
// PAL configuration loader: accepts bytes over valid/ready and shifts exactly SR_LEN bits
// onto the PAL EN/CFG chain, then flags DONE until the next START.
module pal_cfg_loader
    import pal_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 8,
    parameter int P = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              sr_en_o,
    output logic              sr_cfg_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int SR_LEN = pal_sr_len(N, M, P);
    localparam int NBYTES = pal_cfg_bytes(SR_LEN);
    localparam int TW     = $clog2(SR_LEN + 1);
    localparam int BW     = $clog2(NBYTES + 1);

    cfg_state_t    state_q;
    logic [TW-1:0] total_q;
    logic [BW-1:0] bytes_q;
    logic          busy_q;
    logic          done_q;

    logic          hold_ready;
    logic          shift;
    logic          accept;
    logic [TW-1:0] limit;

    assign limit        = TW'(SR_LEN) - total_q;
    assign data_ready_o = (state_q == LOAD) && hold_ready && (bytes_q < BW'(NBYTES));
    // START takes priority over a byte offered in the same cycle.
    assign accept       = data_valid_i && data_ready_o && !start_i;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

    pal_cfg_piso #(
        .LIM_W(TW)
    ) u_piso (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (start_i),
        .byte_i      (data_i),
        .byte_valid_i(accept),
        .byte_ready_o(hold_ready),
        .limit_i     (limit),
        .shift_o     (shift),
        .ser_data_o  (sr_cfg_o),
        .ser_valid_o (sr_en_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            total_q <= '0;
            bytes_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (start_i) begin
            state_q <= LOAD;
            total_q <= '0;
            bytes_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else if (state_q == LOAD) begin
            if (accept) begin
                bytes_q <= bytes_q + 1'b1;
            end
            if (shift) begin
                total_q <= total_q + 1'b1;
            end
            // DONE rises on the same edge that registers the final SR_EN pulse.
            if (shift && (total_q == TW'(SR_LEN - 1))) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench: table-driven full loads against a bit-stream model of the PAL chain,
// plus hand-written sequences for restart, reset, START/VALID collision and a short chain.
module tb_pal_cfg_loader;

    localparam int SR  = pal_pkg::pal_sr_len(8, 8, 8);
    localparam int NB  = pal_pkg::pal_cfg_bytes(SR);
    localparam int SR2 = pal_pkg::pal_sr_len(2, 1, 3);

    typedef struct {
        logic [7:0] fill;
        int         period;
        bit         rnd;
        int         exp_en;
        int         contig;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, dvalid;
    logic [7:0] din;
    logic       dready, sr_en, sr_cfg, busy, done;

    logic       s_start, s_dvalid;
    logic [7:0] s_din;
    logic       s_dready, s_sr_en, s_sr_cfg, s_busy, s_done;

    pal_cfg_loader #(.N(8), .M(8), .P(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_i(din),
        .data_valid_i(dvalid), .data_ready_o(dready), .sr_en_o(sr_en),
        .sr_cfg_o(sr_cfg), .busy_o(busy), .done_o(done)
    );

    pal_cfg_loader #(.N(2), .M(1), .P(3)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .data_i(s_din),
        .data_valid_i(s_dvalid), .data_ready_o(s_dready), .sr_en_o(s_sr_en),
        .sr_cfg_o(s_sr_cfg), .busy_o(s_busy), .done_o(s_done)
    );

    // PAL chain models: shift in CFG on every edge where EN was high before the edge.
    logic [SR-1:0]  chain   = '0;
    logic [SR2-1:0] chain_s = '0;
    int   en_cnt = 0, en_rise = 0, en_cnt_s = 0;
    logic en_prev = 1'b0;

    always @(posedge clk) begin
        en_prev <= sr_en;
        if (sr_en) begin
            chain  <= {chain[SR-2:0], sr_cfg};
            en_cnt <= en_cnt + 1;
            if (!en_prev) en_rise <= en_rise + 1;
        end
        if (s_sr_en) begin
            chain_s  <= {chain_s[SR2-2:0], s_sr_cfg};
            en_cnt_s <= en_cnt_s + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input vec_t v);
        logic [7:0]    bytes [NB+1];
        logic [SR-1:0] exp_chain;
        int idx = 0, cyc = 0, first_acc = -1, done_cyc = -1, base_en, base_rise;
        bit acc, seen = 1'b0;
        for (int i = 0; i <= NB; i++) bytes[i] = v.rnd ? 8'($urandom) : v.fill;
        for (int i = 0; i < SR; i++) exp_chain[SR-1-i] = bytes[i/8][7-(i%8)];
        start  = 1'b1;
        dvalid = 1'b0;
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done_clear", done, 0);
        check("start_ready", dready, 1);
        base_en   = en_cnt;
        base_rise = en_rise;
        while (cyc < 6000 && !seen) begin
            dvalid = (v.period == 0) ? ($urandom_range(0, 3) == 0) : ((cyc % v.period) == 0);
            din    = bytes[idx < NB ? idx : NB];
            @(negedge clk);
            acc = dvalid && dready;
            step();
            cyc++;
            if (acc) begin
                if (first_acc < 0) first_acc = cyc;
                idx++;
            end
            if (done) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        dvalid = 1'b0;
        check("done_seen", seen, 1);
        check("done_with_last_en", sr_en, 1);
        check("busy_at_done", busy, 0);
        if (v.lat >= 0) check("load_latency", done_cyc - first_acc, v.lat);
        step();
        check("en_drop_after_done", sr_en, 0);
        step();
        check("en_count", en_cnt - base_en, v.exp_en);
        if (v.contig >= 0) check("en_contiguous", (en_rise - base_rise) == 1, v.contig);
        check("bytes_accepted", idx, NB);
        check("chain_contents", chain, exp_chain);
        check("done_held", done, 1);
    endtask

    initial begin
        vec_t tbl [4];
        vec_t restart_v;
        int   base, acc_s;
        logic [7:0] s_bytes [3];
        bit   acc, seen;

        tbl[0] = '{fill: 8'hA5, period: 1,  rnd: 1'b0, exp_en: SR, contig: 1,  lat: SR + 1};
        tbl[1] = '{fill: 8'hA5, period: 20, rnd: 1'b0, exp_en: SR, contig: 0,  lat: -1};
        tbl[2] = '{fill: 8'h00, period: 1,  rnd: 1'b1, exp_en: SR, contig: 1,  lat: SR + 1};
        tbl[3] = '{fill: 8'h00, period: 0,  rnd: 1'b1, exp_en: SR, contig: -1, lat: -1};
        restart_v = '{fill: 8'h3C, period: 1, rnd: 1'b0, exp_en: SR, contig: 1, lat: SR + 1};

        rst_n = 1'b0; start = 1'b0; dvalid = 1'b0; din = 8'h00;
        s_start = 1'b0; s_dvalid = 1'b0; s_din = 8'h00;
        step();
        step();
        check("reset_ready", dready, 0);
        check("reset_en", sr_en, 0);
        check("reset_cfg", sr_cfg, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst_n = 1'b1;

        // Valid without START is ignored.
        dvalid = 1'b1; din = 8'hFF;
        base = en_cnt;
        for (int i = 0; i < 5; i++) step();
        check("idle_valid_ready", dready, 0);
        check("idle_valid_busy", busy, 0);
        dvalid = 1'b0;
        step();
        step();
        check("idle_valid_no_shift", en_cnt - base, 0);

        // START and VALID together: byte must not be taken.
        start = 1'b1; dvalid = 1'b1; din = 8'hFF;
        step();
        start = 1'b0; dvalid = 1'b0;
        check("start_wins_ready", dready, 1);
        base = en_cnt;
        for (int i = 0; i < 5; i++) step();
        check("start_wins_no_shift", en_cnt - base, 0);

        // Consecutive loads also exercise START from DONE.
        for (int t = 0; t < 4; t++) run_load(tbl[t]);

        // Abort after 10 bytes, then a full load.
        start = 1'b1;
        step();
        start = 1'b0;
        dvalid = 1'b1; din = 8'h11;
        base = 0;
        for (int i = 0; i < 200 && base < 10; i++) begin
            @(negedge clk);
            acc = dready;
            step();
            if (acc) base++;
        end
        dvalid = 1'b0;
        step();
        step();
        check("partial_busy", busy, 1);
        run_load(restart_v);

        // Reset pulse in the middle of a byte.
        start = 1'b1;
        step();
        start = 1'b0;
        dvalid = 1'b1; din = 8'hFF;
        for (int i = 0; i < 3; i++) step();
        dvalid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midreset_en", sr_en, 0);
        check("midreset_cfg", sr_cfg, 0);
        check("midreset_ready", dready, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        dvalid = 1'b1;
        base = en_cnt;
        for (int i = 0; i < 4; i++) step();
        check("postreset_ready", dready, 0);
        check("postreset_no_shift", en_cnt - base, 0);
        dvalid = 1'b0;

        // Short chain: 15 bits, LSB of the second byte dropped, third byte refused.
        s_bytes[0] = 8'hFF; s_bytes[1] = 8'hFE; s_bytes[2] = 8'h81;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        base  = en_cnt_s;
        acc_s = 0;
        seen  = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            s_dvalid = 1'b1;
            s_din    = s_bytes[acc_s < 2 ? acc_s : 2];
            @(negedge clk);
            acc = s_dready;
            step();
            if (acc) begin
                acc_s++;
                if (acc_s == 2) check("short_ready_after_last", s_dready, 0);
            end
            if (s_done) seen = 1'b1;
        end
        check("short_done_seen", seen, 1);
        step();
        step();
        s_dvalid = 1'b0;
        check("short_accepted", acc_s, 2);
        check("short_en_count", en_cnt_s - base, SR2);
        check("short_chain", chain_s, 15'h7FFF);
        for (int i = 0; i < 4; i++) step();
        check("short_done_held", s_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
